// File: rtl/div_unit.sv
// div_unit: iterative RV32M divider (DIV/DIVU/REM/REMU) for the Execute stage.
// Restoring division, one quotient bit per cycle. While an op is in flight the
// unit requests a pipeline stall; flushE aborts the op from any state.
//
// Handshake: divStartE is a level held by the pipeline while the divide sits
// in Execute. divStallE = divStartE & (state != DONE) & ~flushE. The result is
// valid only in the cycle divDoneE is high; divResultE holds its last value
// otherwise and must be qualified with divDoneE.
module div_unit #(
    parameter int XLEN = 32,
    parameter int CNTW = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            divStartE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] srcAE,
    input  logic [XLEN-1:0] srcBE,
    input  logic            flushE,
    output logic            divStallE,
    output logic            divDoneE,
    output logic [XLEN-1:0] divResultE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    stateT           state;
    logic [CNTW-1:0] counter;
    logic [XLEN-1:0] remR;
    logic [XLEN-1:0] quoR;
    logic [XLEN-1:0] divisorR;
    logic            negQ;
    logic            negR;
    logic            isRem;
    logic [XLEN-1:0] resultHold;

    // Operand decode for the capture cycle; funct3E[2] is always 1 for divides.
    logic            isSignedOp;
    logic            aNeg;
    logic            bNeg;
    logic [XLEN-1:0] absA;
    logic [XLEN-1:0] absB;
    logic            divZero;
    logic            overflow;
    logic            unusedF3;

    // Restoring step datapath: the shifted remainder needs one extra bit
    // because divisors above 2^(XLEN-1) can leave a remainder whose doubled
    // value no longer fits in XLEN bits.
    logic [XLEN:0]   remShift;
    logic [XLEN:0]   remDiff;
    logic            geq;
    logic [XLEN-1:0] fixedResult;

    // Decode operands and the special cases that skip iteration.
    always_comb begin
        unusedF3   = funct3E[2];
        isSignedOp = ~funct3E[0];
        aNeg       = isSignedOp & srcAE[XLEN-1];
        bNeg       = isSignedOp & srcBE[XLEN-1];
        absA       = aNeg ? (~srcAE + 1'b1) : srcAE;
        absB       = bNeg ? (~srcBE + 1'b1) : srcBE;
        divZero    = (srcBE == '0);
        overflow   = isSignedOp & (srcAE == MIN_NEG) & (srcBE == '1);
    end

    // One restoring step plus the sign fix-up of the final result.
    always_comb begin
        remShift    = {remR, quoR[XLEN-1]};
        remDiff     = remShift - {1'b0, divisorR};
        geq         = ~remDiff[XLEN];
        fixedResult = isRem ? (negR ? (~remR + 1'b1) : remR)
                            : (negQ ? (~quoR + 1'b1) : quoR);
    end

    // Stall and done are combinational so the hazard unit reacts this cycle.
    always_comb begin
        divStallE  = divStartE & (state != DONE) & ~flushE;
        divDoneE   = (state == DONE) & ~flushE;
        divResultE = divDoneE ? fixedResult : resultHold;
    end

    // Control FSM and iteration registers; flush overrides every state.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            counter    <= '0;
            remR       <= '0;
            quoR       <= '0;
            divisorR   <= '0;
            negQ       <= 1'b0;
            negR       <= 1'b0;
            isRem      <= 1'b0;
            resultHold <= '0;
        end else if (flushE) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (divStartE) begin
                        isRem <= funct3E[1];
                        if (divZero) begin
                            quoR  <= '1;
                            remR  <= srcAE;
                            negQ  <= 1'b0;
                            negR  <= 1'b0;
                            state <= DONE;
                        end else if (overflow) begin
                            quoR  <= MIN_NEG;
                            remR  <= '0;
                            negQ  <= 1'b0;
                            negR  <= 1'b0;
                            state <= DONE;
                        end else begin
                            remR     <= '0;
                            quoR     <= absA;
                            divisorR <= absB;
                            negQ     <= aNeg ^ bNeg;
                            negR     <= aNeg;
                            counter  <= CNTW'(XLEN);
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    quoR    <= {quoR[XLEN-2:0], geq};
                    remR    <= geq ? remDiff[XLEN-1:0] : remShift[XLEN-1:0];
                    counter <= counter - 1'b1;
                    if (counter == CNTW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // The finished instruction is still in Execute this cycle,
                    // so divStartE is ignored here.
                    resultHold <= fixedResult;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed stimulus for div_unit, checked every
// cycle against a behavioural RV32M division model and a cycle-stamped queue
// of expected results.
module tb_div_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rstN = 1'b0;
    logic            divStartE = 1'b0;
    logic [2:0]      funct3E = 3'd0;
    logic [XLEN-1:0] srcAE = '0;
    logic [XLEN-1:0] srcBE = '0;
    logic            flushE = 1'b0;
    logic            divStallE;
    logic            divDoneE;
    logic [XLEN-1:0] divResultE;

    div_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .divStartE  (divStartE),
        .funct3E    (funct3E),
        .srcAE      (srcAE),
        .srcBE      (srcBE),
        .flushE     (flushE),
        .divStallE  (divStallE),
        .divDoneE   (divDoneE),
        .divResultE (divResultE)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- scoreboard state ----------------
    int              errors = 0;
    int              checks = 0;
    logic [XLEN-1:0] expQ[$];
    int              cycQ[$];
    int              curDone = -1;
    logic [XLEN-1:0] lastRes = '0;

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] refDiv(input logic [2:0] f3,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        longint sa, sb, q, r;
        bit isSigned, wantRem;
        isSigned = ~f3[0];
        wantRem  = f3[1];
        if (b == 0) return wantRem ? a : 32'hFFFF_FFFF;
        if (isSigned && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return wantRem ? 32'h0 : 32'h8000_0000;
        if (isSigned) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return wantRem ? r[XLEN-1:0] : q[XLEN-1:0];
    endfunction

    function automatic bit isSpecial(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        return (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // ---------------- compare process (every negedge) ----------------
    initial begin
        bit expDone;
        bit expStall;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                check("reset_done", {31'b0, divDoneE}, 32'd0);
                check("reset_stall", {31'b0, divStallE}, 32'd0);
                check("reset_result", divResultE, 32'd0);
                lastRes = '0;
            end else begin
                expDone  = (cycQ.size() > 0) && (cycQ[0] == cyc);
                expStall = divStartE && !flushE && (cyc != curDone);
                check("divDoneE", {31'b0, divDoneE}, {31'b0, expDone});
                check("divStallE", {31'b0, divStallE}, {31'b0, expStall});
                if (expDone) begin
                    check("divResultE", divResultE, expQ[0]);
                    lastRes = expQ[0];
                    void'(expQ.pop_front());
                    void'(cycQ.pop_front());
                end else begin
                    check("result_hold", divResultE, lastRes);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issue one divide with divStartE held until the cycle after DONE.
    // Returns #1 after the posedge that starts the following IDLE cycle.
    task automatic doOp(input logic [2:0] f3, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input bit scramble);
        int lat;
        funct3E   = f3;
        srcAE     = a;
        srcBE     = b;
        divStartE = 1'b1;
        lat       = isSpecial(f3, a, b) ? 1 : 33;
        curDone   = cyc + lat;
        expQ.push_back(refDiv(f3, a, b));
        cycQ.push_back(curDone);
        for (int i = 0; i <= lat; i++) begin
            @(posedge clk);
            #1;
            if (scramble && i < lat) begin
                srcAE   = $urandom;
                srcBE   = $urandom;
                funct3E = 3'($urandom_range(4, 7));
            end
        end
    endtask

    task automatic idle(input int n);
        divStartE = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pin(input string name, input logic [2:0] f3, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] lit);
        check(name, refDiv(f3, a, b), lit);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [2:0]      f3;
        logic [XLEN-1:0] a, b;
        int              kind;

        // Model pins from hand-computed values.
        pin("pin_divu", 3'b101, 32'd100, 32'd7, 32'd14);
        pin("pin_remu", 3'b111, 32'd100, 32'd7, 32'd2);
        pin("pin_div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        pin("pin_rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        pin("pin_div_negb", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        pin("pin_rem_negb", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1);
        pin("pin_divu_zero", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
        pin("pin_remu_zero", 3'b111, 32'd5, 32'd0, 32'd5);
        pin("pin_div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        pin("pin_rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        pin("pin_divu_max", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

        // Reset held for a few cycles, then released away from the edge.
        repeat (3) @(posedge clk);
        #1;
        rstN = 1'b1;
        idle(2);

        // Directed cases.
        doOp(3'b101, 32'd100, 32'd7, 1'b1);
        idle(2);
        doOp(3'b111, 32'd100, 32'd7, 1'b1);
        idle(1);
        doOp(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(1);
        doOp(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(1);
        doOp(3'b100, 32'd7, 32'hFFFF_FFFE, 1'b0);
        idle(1);
        doOp(3'b110, 32'd7, 32'hFFFF_FFFE, 1'b0);
        idle(1);
        doOp(3'b101, 32'd5, 32'd0, 1'b1);
        idle(1);
        doOp(3'b111, 32'd5, 32'd0, 1'b0);
        idle(1);
        doOp(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(1);
        doOp(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(2);

        // Flush in the 10th CALC cycle of DIVU 1000/3.
        funct3E   = 3'b101;
        srcAE     = 32'd1000;
        srcBE     = 32'd3;
        divStartE = 1'b1;
        curDone   = cyc + 33;
        expQ.push_back(refDiv(3'b101, 32'd1000, 32'd3));
        cycQ.push_back(curDone);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        flushE = 1'b1;
        void'(expQ.pop_back());
        void'(cycQ.pop_back());
        curDone = -1;
        @(posedge clk);
        #1;
        flushE = 1'b0;
        idle(3);
        doOp(3'b101, 32'd9, 32'd3, 1'b0);
        idle(2);

        // Back-to-back: DONE cycle of the first must not restart it.
        doOp(3'b101, 32'd50, 32'd5, 1'b0);
        doOp(3'b101, 32'd81, 32'd9, 1'b0);
        idle(2);

        // Asynchronous reset in the middle of CALC.
        funct3E   = 3'b101;
        srcAE     = 32'd1000;
        srcBE     = 32'd7;
        divStartE = 1'b1;
        curDone   = cyc + 33;
        expQ.push_back(refDiv(3'b101, 32'd1000, 32'd7));
        cycQ.push_back(curDone);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        #2;
        rstN      = 1'b0;
        divStartE = 1'b0;
        expQ.delete();
        cycQ.delete();
        curDone = -1;
        #1;
        check("async_reset_done", {31'b0, divDoneE}, 32'd0);
        check("async_reset_stall", {31'b0, divStallE}, 32'd0);
        check("async_reset_result", divResultE, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        idle(2);
        doOp(3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0);
        idle(2);

        // Randomized ops, with occasional back-to-back issue.
        for (int n = 0; n < 30; n++) begin
            f3   = 3'($urandom_range(4, 7));
            kind = $urandom_range(0, 9);
            a    = $urandom;
            b    = $urandom;
            case (kind)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 100));
                4: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            doOp(f3, a, b, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        idle(4);

        if (expQ.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL pending: got %0d outstanding results expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
